// File: rtl/anubis_pkg.sv
// anubis_pkg: shared constants, FSM states and round-constant table for the ANUBIS key schedule
package anubis_pkg;
  localparam int KEY_W = 128;
  localparam int MAX_ROUNDS = 12;
  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_LOAD, S_STEP, S_CAPTURE} state_t;
  localparam logic [31:0] RC_TABLE [MAX_ROUNDS] = '{
    32'ha7d3e671, 32'hd0ac4d79, 32'h3ac991fc, 32'h1e4754bd,
    32'h8ca57afb, 32'h63b8ddd4, 32'he5b3c5be, 32'ha9880ca2,
    32'h39df29da, 32'h2ba8cb4c, 32'h4b22aa24, 32'h4170a6f9
  };
  function automatic logic [31:0] rc_word(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'(MAX_ROUNDS)) ? RC_TABLE[r - 4'd1] : 32'h0;
  endfunction
endpackage

// File: rtl/anubis_rc_rom.sv
// anubis_rc_rom: maps round number 1..12 to the 128-bit round constant, zero elsewhere
module anubis_rc_rom #(
  parameter int KEY_W = anubis_pkg::KEY_W
) (
  input  logic [3:0]       r,
  output logic [KEY_W-1:0] rc
);
  import anubis_pkg::*;
  assign rc = {rc_word(r), {(KEY_W-32){1'b0}}};
endmodule

// File: rtl/anubis_key_sched_ctrl.sv
// anubis_key_sched_ctrl: sequences the ANUBIS key evolution and streams R+1 key states
module anubis_key_sched_ctrl #(
  parameter int ROUNDS = 12,
  parameter int KEY_W = anubis_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             evo_load,
  output logic             evo_en,
  output logic [KEY_W-1:0] evo_key,
  output logic [KEY_W-1:0] evo_rc,
  input  logic [KEY_W-1:0] evo_out,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_index
);
  import anubis_pkg::*;
  localparam logic [3:0] LAST = 4'(ROUNDS);
  state_t           state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] rc_next;
  logic [3:0]       r;
  logic [1:0]       phase;
  assign evo_key  = key_reg;
  assign rk_data  = key_reg;
  assign rk_index = r;
  anubis_rc_rom #(.KEY_W(KEY_W)) u_rc_rom (
    .r  (r + 4'd1),
    .rc (rc_next)
  );
  // Key-schedule FSM: emit, load, four phase enables, capture; abort drops straight to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      key_reg  <= '0;
      r        <= '0;
      phase    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      evo_load <= 1'b0;
      evo_en   <= 1'b0;
      evo_rc   <= '0;
      rk_valid <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      evo_load <= 1'b0;
      evo_en   <= 1'b0;
      evo_rc   <= '0;
      rk_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      evo_load <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          key_reg  <= key;
          r        <= '0;
          busy     <= 1'b1;
          rk_valid <= 1'b1;
          state    <= S_EMIT;
        end
        S_EMIT: if (rk_ready) begin
          rk_valid <= 1'b0;
          if (r == LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            r        <= r + 4'd1;
            evo_load <= 1'b1;
            evo_rc   <= rc_next;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          phase  <= '0;
          evo_en <= 1'b1;
          state  <= S_STEP;
        end
        S_STEP: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            evo_en <= 1'b0;
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          key_reg  <= evo_out;
          evo_rc   <= '0;
          rk_valid <= 1'b1;
          state    <= S_EMIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anubis_key_sched_ctrl.sv
// tb_anubis_key_sched_ctrl: directed self-checking bench with a stand-in evolution unit
module tb_anubis_key_sched_ctrl;
  localparam logic [31:0] RCT [12] = '{
    32'ha7d3e671, 32'hd0ac4d79, 32'h3ac991fc, 32'h1e4754bd,
    32'h8ca57afb, 32'h63b8ddd4, 32'he5b3c5be, 32'ha9880ca2,
    32'h39df29da, 32'h2ba8cb4c, 32'h4b22aa24, 32'h4170a6f9
  };
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  logic clk = 1'b0;
  logic reset, start, abort, rk_ready;
  logic [127:0] key, evo_key, evo_rc, evo_out, rk_data;
  logic busy, done, evo_load, evo_en, rk_valid;
  logic [3:0] rk_index;
  logic start1, rk_ready1;
  logic [127:0] key1, evo_key1, evo_rc1, evo_out1, rk_data1;
  logic busy1, done1, evo_load1, evo_en1, rk_valid1;
  logic [3:0] rk_index1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int loads = 0;
  int run_len = 0;
  logic prev_load = 1'b0;
  logic skip_run = 1'b0;
  logic [127:0] ev = '0, ev1 = '0;
  logic [1:0] ph = '0, ph1 = '0;
  int lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  anubis_key_sched_ctrl #(.ROUNDS(12)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .abort(abort),
    .busy(busy), .done(done), .evo_load(evo_load), .evo_en(evo_en),
    .evo_key(evo_key), .evo_rc(evo_rc), .evo_out(evo_out),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index)
  );

  anubis_key_sched_ctrl #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .key(key1), .abort(1'b0),
    .busy(busy1), .done(done1), .evo_load(evo_load1), .evo_en(evo_en1),
    .evo_key(evo_key1), .evo_rc(evo_rc1), .evo_out(evo_out1),
    .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_data(rk_data1), .rk_index(rk_index1)
  );

  function automatic logic [127:0] f(input logic [127:0] x, input logic [127:0] rc, input logic [1:0] p);
    return {x[119:0], x[127:120]} ^ rc ^ {30'b0, p, 96'h12345678_9abcdef0_13579bdf};
  endfunction

  function automatic logic [127:0] rc_of(input int r);
    return {RCT[r-1], 96'b0};
  endfunction

  function automatic logic [127:0] evolve(input logic [127:0] k, input logic [127:0] rc);
    logic [127:0] x = k;
    for (int p = 0; p < 4; p++) x = f(x, rc, 2'(p));
    return x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stand-in evolution units, sampling on the falling edge
  always @(negedge clk) begin
    if (evo_load) begin ev = evo_key; ph = 2'd0; end
    else if (evo_en) begin ev = f(ev, evo_rc, ph); ph = ph + 2'd1; end
    if (evo_load1) begin ev1 = evo_key1; ph1 = 2'd0; end
    else if (evo_en1) begin ev1 = f(ev1, evo_rc1, ph1); ph1 = ph1 + 2'd1; end
  end
  assign evo_out = ev;
  assign evo_out1 = ev1;

  // phase monitor: each evo_en burst follows a load and lasts 4 cycles
  always @(negedge clk) begin
    if (evo_load) loads++;
    if (evo_en) begin
      if (run_len == 0) chk("en_after_load", 128'(prev_load), 128'd1);
      run_len++;
    end else if (run_len != 0) begin
      if (!skip_run) chk("en_run_len", 128'(run_len), 128'd4);
      run_len = 0;
      skip_run = 1'b0;
    end
    prev_load = evo_load;
  end

  task automatic run(input logic [127:0] k, input int stall_at, input int stall_n,
                     input int bs_at, input int ab_rnd, output int lat_o);
    logic [127:0] ref_k [13];
    int idx, stalled, t;
    ref_k[0] = k;
    for (int r = 1; r <= 12; r++) ref_k[r] = evolve(ref_k[r-1], rc_of(r));
    idx = 0; stalled = 0; lat_o = -1; loads = 0;
    rk_ready = 1'b1; start = 1'b1; key = k; t = cyc;
    for (int c = 0; c < 300 && lat_o < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) chk("valid_at_t1", 128'(rk_valid), 128'd1);
      if (evo_en) chk("evo_rc_step", evo_rc, rc_of(idx));
      if (evo_load && idx == 1) chk("rc_round1", evo_rc, {32'ha7d3e671, 96'b0});
      if (evo_load && idx == 2) chk("rc_round2", evo_rc, {32'hd0ac4d79, 96'b0});
      if (done) begin
        lat_o = cyc - t;
        chk("busy_at_done", 128'(busy), 128'd0);
        chk("states_emitted", 128'(idx), 128'd13);
      end else if (ab_rnd > 0 && evo_en && idx == ab_rnd) begin
        abort = 1'b1; skip_run = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_en", 128'(evo_en), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        @(negedge clk);
        chk("abort_no_done", 128'(done), 128'd0);
        lat_o = 0;
      end else if (rk_valid) begin
        chk("rk_index", 128'(rk_index), 128'(idx));
        chk("rk_data", rk_data, ref_k[idx]);
        if (idx == stall_at && stalled < stall_n) begin
          rk_ready = 1'b0;
          chk("stall_no_evo", 128'({evo_en, evo_load}), 128'd0);
          stalled++;
        end else begin
          rk_ready = 1'b1;
          chk("evo_rc_emit", evo_rc, 128'd0);
          if (idx == bs_at) begin start = 1'b1; key = ~k; end
          idx++;
        end
      end
    end
    if (lat_o > 0) begin
      @(negedge clk);
      chk("done_pulse_one", 128'(done), 128'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; key = KEY0; abort = 1'b0; rk_ready = 1'b1;
    start1 = 1'b1; key1 = KEY0; rk_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    chk("rst_outs", 128'({busy, done, evo_load, evo_en, rk_valid, rk_index}), 128'd0);
    chk("rst_key", evo_key | rk_data | evo_rc, 128'd0);
    chk("rst_outs1", 128'({busy1, done1, evo_load1, evo_en1, rk_valid1, rk_index1}), 128'd0);
    @(negedge clk);
    chk("start_in_reset", 128'({busy, busy1}), 128'd0);

    run(KEY0, -1, 0, -1, -1, lat);
    chk("lat_full", 128'(lat), 128'd86);
    chk("loads_full", 128'(loads), 128'd12);
    run(128'hfedcba98765432100123456789abcdef, 3, 5, -1, -1, lat);
    chk("lat_stall", 128'(lat), 128'd91);
    run(128'h0badf00d_deadbeef_cafebabe_00c0ffee, -1, 0, 5, -1, lat);
    chk("lat_busy_start", 128'(lat), 128'd86);
    run(128'h11112222333344445555666677778888, -1, 0, -1, 7, lat);
    chk("abort_seen", 128'(lat), 128'd0);
    run(128'h0f0e0d0c0b0a09080706050403020100, -1, 0, -1, -1, lat);
    chk("lat_restart", 128'(lat), 128'd86);
    chk("loads_restart", 128'(loads), 128'd12);

    begin
      int n1, lat1, t1;
      n1 = 0; lat1 = -1;
      start1 = 1'b1; key1 = KEY0; t1 = cyc;
      for (int c = 0; c < 40 && lat1 < 0; c++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1) lat1 = cyc - t1;
        else if (rk_valid1) begin
          chk("r1_index", 128'(rk_index1), 128'(n1));
          chk("r1_data", rk_data1, n1 == 0 ? KEY0 : evolve(KEY0, rc_of(1)));
          n1++;
        end
      end
      chk("r1_lat", 128'(lat1), 128'd9);
      chk("r1_states", 128'(n1), 128'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
